// File: rtl/wdt_pkg.sv
// Shared types and constants for the multi-channel watchdog.
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WARN = 2'd2,
        BITE = 2'd3
    } wdt_state_e;

    localparam logic [1:0] WR_SEL_CTRL    = 2'd0;
    localparam logic [1:0] WR_SEL_TIMEOUT = 2'd1;
    localparam logic [1:0] WR_SEL_WINDOW  = 2'd2;
    localparam logic [1:0] WR_SEL_KICK    = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_WIN  = 1;
    localparam int CTRL_LOCK = 2;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: config registers, prescaler, counter and the
// IDLE/RUN/WARN/BITE state machine.
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int              CNT_W       = 16,
    parameter int              PRESC       = 4,
    parameter logic [CNT_W-1:0] DEF_TIMEOUT = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             key_ok,
    output logic             irq,
    output logic             bite_next,
    output logic [CNT_W-1:0] cnt
);

    localparam int            PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

    wdt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] timeout_q, timeout_d;
    logic [CNT_W-1:0] window_q, window_d;
    logic             win_mode_q, win_mode_d;
    logic             lock_q, lock_d;
    logic             irq_q, irq_d;

    logic ctrl_wr, timeout_wr, window_wr, kick;
    logic active, tick, expire;

    assign ctrl_wr    = wr_en && (wr_sel == WR_SEL_CTRL)    && !lock_q;
    assign timeout_wr = wr_en && (wr_sel == WR_SEL_TIMEOUT) && !lock_q;
    assign window_wr  = wr_en && (wr_sel == WR_SEL_WINDOW)  && !lock_q;
    assign kick       = wr_en && (wr_sel == WR_SEL_KICK)    && key_ok;

    assign active = (state_q == RUN) || (state_q == WARN);
    assign tick   = active && (presc_q == PRESC_MAX);
    // >= so a TIMEOUT lowered below the live count still expires instead of wrapping
    assign expire = tick && (cnt_q >= timeout_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        irq_d      = irq_q;
        timeout_d  = timeout_q;
        window_d   = window_q;
        win_mode_d = win_mode_q;
        lock_d     = lock_q;

        if (active) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (ctrl_wr && wr_data[CTRL_EN]) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    presc_d = '0;
                    irq_d   = 1'b0;
                end
            end
            RUN, WARN: begin
                if (ctrl_wr && !wr_data[CTRL_EN]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    presc_d = '0;
                    irq_d   = 1'b0;
                end else if (kick) begin
                    if ((state_q == RUN) && win_mode_q && (cnt_q < window_q)) begin
                        state_d = BITE;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        presc_d = '0;
                        irq_d   = 1'b0;
                    end
                end else if (expire) begin
                    irq_d = 1'b1;
                    if (state_q == RUN) begin
                        state_d = WARN;
                        cnt_d   = '0;
                    end else begin
                        state_d = BITE;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BITE: begin
            end
        endcase

        if (ctrl_wr) begin
            win_mode_d = wr_data[CTRL_WIN];
            lock_d     = wr_data[CTRL_LOCK];
        end
        if (timeout_wr) begin
            timeout_d = wr_data;
        end
        if (window_wr) begin
            window_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            presc_q    <= '0;
            timeout_q  <= DEF_TIMEOUT;
            window_q   <= '0;
            win_mode_q <= 1'b0;
            lock_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            timeout_q  <= timeout_d;
            window_q   <= window_d;
            win_mode_q <= win_mode_d;
            lock_q     <= lock_d;
            irq_q      <= irq_d;
        end
    end

    // Lets the top register wto_rst on the same edge the channel bites.
    assign bite_next = (state_d == BITE);
    assign irq       = irq_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/wdt_multi_channel.sv
// NUM_CH independent watchdog channels with shared write decode, shared kick-key
// compare and a sticky OR-reduced reset request.
module wdt_multi_channel
    import wdt_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 16,
    parameter int               PRESC       = 4,
    parameter logic [CNT_W-1:0] DEF_TIMEOUT = 16'hFFFF,
    parameter logic [31:0]      KICK_KEY    = 32'h5A5A_A5A5,
    localparam int              CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    wdt_clk,
    input  logic                    wdt_rst_n,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [1:0]              wr_sel,
    input  logic [31:0]             wr_data,
    output logic [NUM_CH-1:0]       wto_irq,
    output logic                    wto_rst,
    output logic [NUM_CH*CNT_W-1:0] ch_cnt
);

    logic              key_ok;
    logic [NUM_CH-1:0] bite_next;
    logic              wto_rst_q, wto_rst_d;

    assign key_ok = (wr_data == KICK_KEY);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic ch_wr;
        // Channel indices at or above NUM_CH never match, so such writes drop out here.
        assign ch_wr = wr_en && (wr_ch == CH_W'(gi));

        wdt_channel #(
            .CNT_W       (CNT_W),
            .PRESC       (PRESC),
            .DEF_TIMEOUT (DEF_TIMEOUT)
        ) u_channel (
            .clk       (wdt_clk),
            .rst_n     (wdt_rst_n),
            .wr_en     (ch_wr),
            .wr_sel    (wr_sel),
            .wr_data   (wr_data[CNT_W-1:0]),
            .key_ok    (key_ok),
            .irq       (wto_irq[gi]),
            .bite_next (bite_next[gi]),
            .cnt       (ch_cnt[gi*CNT_W +: CNT_W])
        );
    end

    assign wto_rst_d = wto_rst_q | (|bite_next);

    always_ff @(posedge wdt_clk or negedge wdt_rst_n) begin
        if (!wdt_rst_n) begin
            wto_rst_q <= 1'b0;
        end else begin
            wto_rst_q <= wto_rst_d;
        end
    end

    assign wto_rst = wto_rst_q;

endmodule
